// File: rtl/decimal_entry_pkg.sv
// Shared key codes and FSM state encoding for decimal_entry.
package decimal_entry_pkg;

  localparam logic [3:0] KEY_BACKSPACE = 4'd10;
  localparam logic [3:0] KEY_CLEAR     = 4'd11;
  localparam logic [3:0] KEY_ENTER     = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/decimal_entry_step.sv
// One decimal-to-binary step: acc*10 + digit, saturating to all ones once it exceeds the width.
// Purely combinational; no handshake.
module decimal_entry_step #(
  parameter int NUMBER_WIDTH = 16
) (
  input  logic [NUMBER_WIDTH-1:0] acc,
  input  logic [3:0]              digit,
  input  logic                    ovf_in,
  output logic [NUMBER_WIDTH-1:0] acc_next,
  output logic                    ovf_next
);

  // Four extra bits hold acc*10 + 9 for any acc without wrapping.
  logic [NUMBER_WIDTH+3:0] sum;

  assign sum = ({4'd0, acc} * (NUMBER_WIDTH + 4)'(10)) + {{NUMBER_WIDTH{1'b0}}, digit};

  always_comb begin
    ovf_next = ovf_in || (sum[NUMBER_WIDTH+3:NUMBER_WIDTH] != 4'd0);
    acc_next = ovf_next ? {NUMBER_WIDTH{1'b1}} : sum[NUMBER_WIDTH-1:0];
  end

endmodule

// File: rtl/decimal_entry.sv
// Keypad decimal entry: BCD buffer with backspace/clear; enter converts to saturating binary.
// Result pulses DIGITS_COUNT+1 cycles after enter; key_ready drops while converting.
module decimal_entry
  import decimal_entry_pkg::*;
#(
  parameter int NUMBER_WIDTH = 16,
  localparam int DIGITS_COUNT = $rtoi($ceil(NUMBER_WIDTH * $log10(2))),
  localparam int COUNT_WIDTH  = $clog2(DIGITS_COUNT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_valid,
  input  logic [3:0]                key_code,
  output logic                      key_ready,
  output logic [4*DIGITS_COUNT-1:0] bcd,
  output logic [COUNT_WIDTH-1:0]    digit_count,
  output logic [NUMBER_WIDTH-1:0]   value,
  output logic                      value_valid,
  output logic                      overflow
);

  localparam int IDX_WIDTH = (DIGITS_COUNT > 1) ? $clog2(DIGITS_COUNT) : 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_FULL = COUNT_WIDTH'(DIGITS_COUNT);
  localparam logic [IDX_WIDTH-1:0]   IDX_LAST   = IDX_WIDTH'(DIGITS_COUNT - 1);

  state_t                         state_q, state_d;
  logic [DIGITS_COUNT-1:0][3:0]   buf_q;
  logic [COUNT_WIDTH-1:0]         count_q;
  logic [IDX_WIDTH-1:0]           idx_q;
  logic [NUMBER_WIDTH-1:0]        acc_q, acc_next;
  logic                           ovf_q, ovf_next;
  logic                           key_fire;

  assign key_fire    = key_valid && key_ready;
  assign bcd         = buf_q;
  assign digit_count = count_q;

  decimal_entry_step #(
    .NUMBER_WIDTH(NUMBER_WIDTH)
  ) u_step (
    .acc      (acc_q),
    .digit    (buf_q[idx_q]),
    .ovf_in   (ovf_q),
    .acc_next (acc_next),
    .ovf_next (ovf_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    key_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        key_ready = 1'b1;
        if (key_valid && key_code == KEY_ENTER) begin
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (idx_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q       <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      value       <= '0;
      overflow    <= 1'b0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (key_fire) begin
            if (key_code <= 4'd9) begin
              // A full buffer swallows further digits silently.
              if (count_q != COUNT_FULL) begin
                buf_q   <= {buf_q[DIGITS_COUNT-2:0], key_code};
                count_q <= count_q + COUNT_WIDTH'(1);
              end
            end else if (key_code == KEY_BACKSPACE) begin
              if (count_q != '0) begin
                buf_q   <= {4'd0, buf_q[DIGITS_COUNT-1:1]};
                count_q <= count_q - COUNT_WIDTH'(1);
              end
            end else if (key_code == KEY_CLEAR) begin
              buf_q   <= '0;
              count_q <= '0;
            end else if (key_code == KEY_ENTER) begin
              idx_q <= IDX_LAST;
              acc_q <= '0;
              ovf_q <= 1'b0;
            end
          end
        end
        ST_CONVERT: begin
          acc_q <= acc_next;
          ovf_q <= ovf_next;
          idx_q <= idx_q - IDX_WIDTH'(1);
          // The last step still reads digit 0 this cycle, so clearing here is safe.
          if (idx_q == '0) begin
            buf_q   <= '0;
            count_q <= '0;
          end
        end
        ST_DONE: begin
          value       <= acc_q;
          overflow    <= ovf_q;
          value_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decimal_entry.sv
// Bench for decimal_entry at NUMBER_WIDTH=16: scoreboarded results with latency checks.
module tb_decimal_entry;
  import decimal_entry_pkg::*;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [19:0] bcd;
  logic [2:0]  digit_count;
  logic [15:0] value;
  logic        value_valid;
  logic        overflow;

  typedef struct {
    int v;
    bit o;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  decimal_entry #(.NUMBER_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .bcd         (bcd),
    .digit_count (digit_count),
    .value       (value),
    .value_valid (value_valid),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: every pulse must match the oldest expectation, value, flag and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (value_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: value=%0d overflow=%0b, required no pulse", value, overflow);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (value !== e.v[15:0]) begin
          errors++;
          $display("FAIL result_value: got %0d, required %0d", value, e.v);
        end
        checks++;
        if (overflow !== e.o) begin
          errors++;
          $display("FAIL result_overflow: got %0b, required %0b", overflow, e.o);
        end
        checks++;
        if (cyc != e.at) begin
          errors++;
          $display("FAIL result_latency: pulse at cycle %0d, required %0d", cyc, e.at);
        end
      end
    end
  end

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic do_enter(input int ev, input bit eo);
    exp_t e;
    press(KEY_ENTER);
    e.v  = ev;
    e.o  = eo;
    e.at = cyc + 6;
    exp_q.push_back(e);
    checks++;
    if (key_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: key_ready=%0b, required 0", key_ready);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL result_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (bcd !== 20'h0 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL cleared_after_done: bcd=%h count=%0d, required 00000 and 0", bcd, digit_count);
    end
  endtask

  task automatic check_buf(input string name, input logic [19:0] eb, input logic [2:0] ec);
    checks++;
    if (bcd !== eb || digit_count !== ec) begin
      errors++;
      $display("FAIL %s: bcd=%h count=%0d, required bcd=%h count=%0d", name, bcd, digit_count, eb, ec);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || bcd !== 20'h0 || digit_count !== 3'd0 ||
        value !== 16'd0 || value_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%0b bcd=%h count=%0d value=%0d vld=%0b ovf=%0b, required 1 0 0 0 0 0",
               key_ready, bcd, digit_count, value, value_valid, overflow);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    press(4'd1);
    press(4'd2);
    press(4'd3);
    check_buf("basic_buffer", 20'h00123, 3'd3);
    do_enter(123, 1'b0);
    wait_done();
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_done: key_ready=%0b, required 1", key_ready);
    end
  endtask

  task automatic test_saturate();
    int d1[5] = '{6, 5, 5, 3, 5};
    int d2[5] = '{6, 5, 5, 3, 6};
    for (int i = 0; i < 5; i++) press(4'(d1[i]));
    do_enter(65535, 1'b0);
    wait_done();
    for (int i = 0; i < 5; i++) press(4'(d2[i]));
    check_buf("sat_buffer", 20'h65536, 3'd5);
    do_enter(65535, 1'b1);
    wait_done();
    for (int i = 0; i < 5; i++) press(4'd9);
    do_enter(65535, 1'b1);
    wait_done();
  endtask

  task automatic test_random();
    int n, d, val;
    logic [19:0] eb;
    for (int it = 0; it < 4; it++) begin
      n   = $urandom_range(1, 5);
      val = 0;
      eb  = 20'h0;
      for (int k = 0; k < n; k++) begin
        d   = $urandom_range(0, 9);
        press(4'(d));
        val = val * 10 + d;
        eb  = {eb[15:0], 4'(d)};
      end
      check_buf("random_buffer", eb, 3'(n));
      if (val > 65535) do_enter(65535, 1'b1);
      else             do_enter(val, 1'b0);
      wait_done();
    end
  endtask

  task automatic test_full_backspace();
    for (int i = 1; i <= 6; i++) press(4'(i));
    check_buf("full_ignore", 20'h12345, 3'd5);
    press(KEY_BACKSPACE);
    press(KEY_BACKSPACE);
    check_buf("backspace_twice", 20'h00123, 3'd3);
    do_enter(123, 1'b0);
    wait_done();
  endtask

  task automatic test_empty_clear_ignored();
    press(KEY_BACKSPACE);
    check_buf("backspace_empty", 20'h0, 3'd0);
    press(KEY_CLEAR);
    do_enter(0, 1'b0);
    wait_done();
    press(4'd4);
    press(4'd13);
    press(4'd14);
    press(4'd15);
    check_buf("ignored_codes", 20'h00004, 3'd1);
    press(KEY_CLEAR);
    check_buf("clear", 20'h0, 3'd0);
  endtask

  task automatic test_held_key();
    exp_t e;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = KEY_ENTER;
    @(negedge clk);
    key_code = 4'd7;
    e.v  = 0;
    e.o  = 1'b0;
    e.at = cyc + 6;
    exp_q.push_back(e);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (key_ready !== 1'b0 || bcd !== 20'h0) begin
        errors++;
        $display("FAIL held_busy[%0d]: ready=%0b bcd=%h, required 0 and 00000", i, key_ready, bcd);
      end
      @(negedge clk);
    end
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL held_ready_return: key_ready=%0b, required 1", key_ready);
    end
    @(negedge clk);
    key_valid = 1'b0;
    check_buf("held_consumed", 20'h00007, 3'd1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL held_result: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    press(KEY_CLEAR);
  endtask

  task automatic test_reset_midconvert();
    press(4'd4);
    press(4'd2);
    do_enter(42, 1'b0);
    wait_done();
    press(4'd9);
    press(KEY_ENTER);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (key_ready !== 1'b1 || bcd !== 20'h0 || value !== 16'd0 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: ready=%0b bcd=%h value=%0d count=%0d, required 1 00000 0 0",
               key_ready, bcd, value, digit_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (value !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_value: value=%0d overflow=%0b, required 0 and 0", value, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_full_backspace();
    test_empty_clear_ignored();
    test_random();
    test_held_key();
    test_reset_midconvert();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decimal_entry.md
# decimal_entry

Keypad-driven decimal number entry: the input-side counterpart of `number_display`. It collects decimal digit key presses into a BCD buffer, supports backspace and clear, and echoes the buffer so a display can show the number being typed. On enter, it converts the buffer to a binary `NUMBER_WIDTH`-bit value over a fixed number of cycles, saturating on overflow. It sits between a key scanner and any block that consumes a binary number, such as a counter preset.

## Interface
- `NUMBER_WIDTH`, default 16: width of the binary result.
- `DIGITS_COUNT`, localparam = `$rtoi($ceil(NUMBER_WIDTH * $log10(2)))`: buffer depth in digits (5 for width 16).

- `clk`  input  1: the single clock; all state updates on its rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `key_valid`  input  1: a key code is offered.
- `key_code`  input  4: 0–9 = digit, 10 = backspace, 11 = clear, 12 = enter, 13–15 = ignored.
- `key_ready`  output  1: high only in IDLE; a key is consumed when `key_valid && key_ready` at a clock edge.
- `bcd`  output  `4*DIGITS_COUNT`: entry buffer; digit 0 (the least significant digit) is in bits [3:0]; unused positions read 0.
- `digit_count`  output  `$clog2(DIGITS_COUNT+1)`: number of digits entered.
- `value`  output  `NUMBER_WIDTH`: last conversion result; held until the next result.
- `value_valid`  output  1: one-cycle pulse when `value` updates.
- `overflow`  output  1: set with each result if it saturated; held with `value`.

## Operation
- States: IDLE, CONVERT, DONE.
- **IDLE, digit key:**
  - If `digit_count < DIGITS_COUNT`: shift the buffer up one digit, insert the key at digit 0, and increment the count.
  - If the buffer is full, the key is consumed and ignored.
  - Leading zeros are accepted and counted.
- **IDLE, backspace:**
  - If count > 0: shift the buffer down one digit, zero-fill the top digit, and decrement the count.
  - If count = 0: no effect.
- **IDLE, clear:** buffer and count go to 0.
- **IDLE, codes 13–15:** consumed, no effect.
- **IDLE, enter:** go to CONVERT with step index = `DIGITS_COUNT-1`, accumulator = 0, and the overflow flag cleared. This happens even when count = 0, giving result 0.
- **CONVERT, each cycle:**
  - Compute `acc*10 + bcd[index]` at `NUMBER_WIDTH+4` bits.
  - If that is ≥ `2**NUMBER_WIDTH`, or the overflow flag is already set, then acc = all ones and the flag is set.
  - Otherwise acc takes the new value.
  - Decrement the index. After step index 0, go to DONE.
- **DONE, one cycle:**
  - `value` = acc and `overflow` = flag, both registered.
  - `value_valid` = 1.
  - Buffer and count are cleared.
  - Return to IDLE.
- `bcd` and `digit_count` stay frozen during CONVERT and read 0 from DONE onward.
- **Reset values:** state IDLE, `key_ready` 1, `bcd` 0, `digit_count` 0, `value` 0, `value_valid` 0, `overflow` 0.
- **Reset mid-CONVERT or mid-DONE:** immediate return to the reset values. The conversion is abandoned and no pulse is produced.

## Timing
- A key presented in IDLE is consumed at that edge. `bcd` and `digit_count` reflect it in the next cycle.
- One key per cycle is accepted back-to-back in IDLE.
- Enter consumed at edge E: CONVERT occupies the `DIGITS_COUNT` cycles after E. `value_valid` is high in the cycle following edge E+`DIGITS_COUNT`+1, i.e. cycle E+`DIGITS_COUNT`+1, which is cycle E+6 for width 16.
- The latency is fixed and independent of `digit_count`.
- `key_ready` is low from the cycle after E through the DONE cycle inclusive. It returns high in the cycle after DONE.
- A key held through the busy period is consumed on the first IDLE edge.
- `value` and `overflow` change only in the DONE cycle.

## Structure
- Package `decimal_entry_pkg`:
  - Constants `KEY_BACKSPACE` = 4'd10, `KEY_CLEAR` = 4'd11, `KEY_ENTER` = 4'd12.
  - The state enum typedef.
- Sub-module `decimal_entry_step`: combinational `acc*10 + digit` with the saturate/overflow decision.
- The FSM, digit buffer and output registers live in `decimal_entry`.

## Test plan (NUMBER_WIDTH = 16)
- Keys 1,2,3 then enter → `bcd` = 0x00123 before enter; after enter, `value` = 123, `overflow` = 0, and `value_valid` is high for exactly one cycle, 6 cycles after the enter edge. `digit_count` then reads 0.
- 6,5,5,3,5 then enter → `value` = 65535, `overflow` = 0. Then 6,5,5,3,6 then enter → `value` = 65535, `overflow` = 1. Then 9,9,9,9,9 then enter → `value` = 65535, `overflow` = 1.
- 1,2,3,4,5,6 → the 6 is ignored, `bcd` = 0x12345, count = 5. Then backspace twice → `bcd` = 0x00123, count = 3. Then enter → `value` = 123.
- Backspace on an empty buffer, then clear, then enter → `value` = 0, `overflow` = 0, with one `value_valid` pulse. Codes 13–15 leave `bcd` unchanged.
- Digit 7 held on `key_valid` from the enter edge onward → `key_ready` is low for 6 cycles and the 7 is not consumed. It is consumed on the first IDLE edge, giving `bcd` = 0x00007.
- `rst` driven low 3 cycles after enter → no `value_valid` pulse; `value` = 0, `bcd` = 0, `key_ready` = 1 immediately and asynchronously.
